stereo_pix_arbiter: RTL and testbench

STEREO_PIX_ARBITER -- requirements
Module: stereo_pix_arbiter

---
 rtl/stereo_pix_arbiter_pkg.sv | 14 +
 rtl/stereo_pix_arbiter_fifo.sv | 58 +++++
 rtl/stereo_pix_arbiter.sv | 137 +++++++++++++
 tb/tb_stereo_pix_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_pix_arbiter_pkg.sv
// Shared types and constants for the stereo pixel arbiter.
// Pixel width, default frame geometry, camera sync state.
package stereo_pkg;

    localparam int PIX_W      = 10;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_HEIGHT = 16;

    typedef enum logic {
        CAM_UNSYNC = 1'b0,
        CAM_RUN    = 1'b1
    } cam_state_t;

endpackage

// File: rtl/stereo_pix_arbiter_fifo.sv
// pix_fifo: small synchronous FIFO, DEPTH (power of two) x DW.
// Ports: clock, reset, push/din, pop/dout (show-ahead), full, empty.
module pix_fifo
    import stereo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = PIX_W + 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    // A pop frees the slot the push fills, so full+pop+push is legal.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wptr] <= din;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (do_pop && !do_push)
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/stereo_pix_arbiter.sv
// Merges two camera pixel streams into one frame-buffer write port.
// Ports: clock, reset, l_/r_ valid/gray/frame, mem_ready, mem_we/
// mem_addr/mem_wdata, frame_done pulse, sticky overflow/sync_err.
module stereo_pix_arbiter
    import stereo_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 l_valid,
    input  logic [PIX_W-1:0]                     l_gray,
    input  logic                                 l_frame,
    input  logic                                 r_valid,
    input  logic [PIX_W-1:0]                     r_gray,
    input  logic                                 r_frame,
    input  logic                                 mem_ready,
    output logic                                 mem_we,
    output logic [$clog2(WIDTH*HEIGHT):0]        mem_addr,
    output logic [PIX_W-1:0]                     mem_wdata,
    output logic                                 frame_done,
    output logic                                 overflow,
    output logic                                 sync_err
);

    localparam int N  = WIDTH * HEIGHT;
    localparam int IW = $clog2(N);
    localparam int EW = PIX_W + IW;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [1:0]             v;
    logic [1:0]             f;
    logic [PIX_W-1:0]       g     [2];
    cam_state_t             st    [2];
    logic [IW-1:0]          idx   [2];
    logic [IW-1:0]          pidx  [2];
    logic [EW-1:0]          din   [2];
    logic [EW-1:0]          dout  [2];
    logic [1:0]             accept;
    logic [1:0]             push;
    logic [1:0]             drop;
    logic [1:0]             resync;
    logic [1:0]             full;
    logic [1:0]             empty;
    logic [1:0]             grant;
    logic [1:0]             set;
    logic [1:0]             done;
    logic                   pri_r;
    logic                   fin;

    assign v    = {r_valid, l_valid};
    assign f    = {r_frame, l_frame};
    assign g[0] = l_gray;
    assign g[1] = r_gray;

    // Right wins a tie only when left went last.
    assign grant[1] = mem_ready && !empty[1]
                   && (empty[0] || pri_r);
    assign grant[0] = mem_ready && !empty[0]
                   && !grant[1];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            accept[c] = v[c] && (st[c] == CAM_RUN || f[c]);
            pidx[c]   = f[c] ? '0 : idx[c];
            push[c]   = accept[c] && (!full[c] || grant[c]);
            drop[c]   = accept[c] && full[c] && !grant[c];
            resync[c] = v[c] && f[c] && st[c] == CAM_RUN
                     && idx[c] != '0;
            din[c]    = {pidx[c], g[c]};
            // Done is taken when the last pixel reaches memory.
            set[c]    = grant[c]
                     && dout[c][EW-1:PIX_W] == LAST;
        end
    end

    assign fin = (done[0] | set[0]) & (done[1] | set[1]);

    for (genvar c = 0; c < 2; c++) begin : g_fifo
        pix_fifo #(
            .DEPTH (FIFO_DEPTH),
            .DW    (EW)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (push[c]),
            .din   (din[c]),
            .pop   (grant[c]),
            .dout  (dout[c]),
            .full  (full[c]),
            .empty (empty[c])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                st[c]  <= CAM_UNSYNC;
                idx[c] <= '0;
            end
            done       <= '0;
            pri_r      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    st[c]  <= CAM_RUN;
                    idx[c] <= (pidx[c] == LAST) ? '0
                            : pidx[c] + 1'b1;
                end
            end
            done       <= fin ? 2'b00 : (done | set);
            frame_done <= fin;
            overflow   <= overflow | (|drop);
            sync_err   <= sync_err | (|resync);
            mem_we     <= |grant;
            if (|grant) begin
                pri_r <= grant[0];
                if (grant[1]) begin
                    mem_addr  <= {1'b1, dout[1][EW-1:PIX_W]};
                    mem_wdata <= dout[1][PIX_W-1:0];
                end else begin
                    mem_addr  <= {1'b0, dout[0][EW-1:PIX_W]};
                    mem_wdata <= dout[0][PIX_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_stereo_pix_arbiter.sv
// Directed self-checking bench for stereo_pix_arbiter.
// Default 16x16 frame, FIFO depth 4.
module tb_stereo_pix_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       l_valid = 1'b0;
    logic [9:0] l_gray = '0;
    logic       l_frame = 1'b0;
    logic       r_valid = 1'b0;
    logic [9:0] r_gray = '0;
    logic       r_frame = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_we;
    logic [8:0] mem_addr;
    logic [9:0] mem_wdata;
    logic       frame_done;
    logic       overflow;
    logic       sync_err;

    int ncmp = 0;
    int nbad = 0;

    always #5 clock = ~clock;

    stereo_pix_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .l_valid    (l_valid),
        .l_gray     (l_gray),
        .l_frame    (l_frame),
        .r_valid    (r_valid),
        .r_gray     (r_gray),
        .r_frame    (r_frame),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .frame_done (frame_done),
        .overflow   (overflow),
        .sync_err   (sync_err)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h exp=%0h",
                     tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        l_valid = 1'b0;
        l_frame = 1'b0;
        r_valid = 1'b0;
        r_frame = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        mem_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".we"},   32'(mem_we),     0);
        chk({tag, ".addr"}, 32'(mem_addr),   0);
        chk({tag, ".data"}, 32'(mem_wdata),  0);
        chk({tag, ".fd"},   32'(frame_done), 0);
        chk({tag, ".ovf"},  32'(overflow),   0);
        chk({tag, ".serr"}, 32'(sync_err),   0);
    endtask

    task automatic chk_wr(input string tag,
                          input int addr,
                          input int data);
        chk({tag, ".we"},   32'(mem_we),    1);
        chk({tag, ".addr"}, 32'(mem_addr),  32'(addr));
        chk({tag, ".data"}, 32'(mem_wdata), 32'(data));
    endtask

    function automatic logic [9:0] lval(input int k);
        return 10'((k * 5 + 1) % 1024);
    endfunction

    function automatic logic [9:0] rval(input int k);
        return 10'((k * 7 + 500) % 1024);
    endfunction

    initial begin
        // Reset values and pre-marker pixels
        do_reset();
        chk_zero("rst");
        for (int i = 0; i < 3; i++) begin
            l_valid = 1'b1;
            l_gray  = 10'(i + 1);
            r_valid = 1'b1;
            r_gray  = 10'(i + 9);
            cyc();
            chk("nosync.we", 32'(mem_we), 0);
        end
        idle_in();
        cyc();

        // Left-only full frame
        for (int i = 0; i <= 256; i++) begin
            if (i < 256) begin
                l_valid = 1'b1;
                l_frame = (i == 0);
                l_gray  = lval(i);
            end else begin
                idle_in();
            end
            cyc();
            if (i > 0)
                chk_wr("lonly", i - 1, 32'(lval(i - 1)));
            else
                chk("lonly.we0", 32'(mem_we), 0);
            chk("lonly.fd", 32'(frame_done), 0);
        end
        cyc();
        chk("lonly.idle", 32'(mem_we), 0);
        chk("hold.addr", 32'(mem_addr), 32'h0ff);
        chk("hold.data", 32'(mem_wdata), 32'(lval(255)));
        chk("lonly.serr", 32'(sync_err), 0);

        // Both cameras at half rate, alternating writes
        do_reset();
        for (int t = 0; t <= 513; t++) begin
            if (t % 2 == 0 && t / 2 < 256) begin
                l_valid = 1'b1;
                r_valid = 1'b1;
                l_frame = (t == 0);
                r_frame = (t == 0);
                l_gray  = lval(t / 2);
                r_gray  = rval(t / 2);
            end else begin
                idle_in();
            end
            cyc();
            if (t % 2 == 1 && (t - 1) / 2 < 256)
                chk_wr("both.L", (t - 1) / 2,
                       32'(lval((t - 1) / 2)));
            else if (t % 2 == 0 && t >= 2)
                chk_wr("both.R", 256 + t / 2 - 1,
                       32'(rval(t / 2 - 1)));
            else
                chk("both.we0", 32'(mem_we), 0);
            chk("both.fd", 32'(frame_done),
                32'(t == 512));
        end

        // Overflow while memory stalls
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            l_valid = 1'b1;
            l_frame = (i == 0);
            l_gray  = 10'(100 + i);
            cyc();
            chk("stall.we", 32'(mem_we), 0);
        end
        chk("stall.ovf", 32'(overflow), 1);
        mem_ready = 1'b1;
        l_frame   = 1'b0;
        l_gray    = 10'd600;
        for (int j = 0; j < 5; j++) begin
            cyc();
            idle_in();
            if (j < 4)
                chk_wr("drain", j, 100 + j);
            else
                chk_wr("fullpp", 4, 600);
        end
        cyc();
        chk("drain.idle", 32'(mem_we), 0);
        chk("drain.serr", 32'(sync_err), 0);

        // Right marker at index 100
        do_reset();
        for (int i = 0; i < 100; i++) begin
            r_valid = 1'b1;
            r_frame = (i == 0);
            r_gray  = rval(i);
            cyc();
        end
        chk("pre.serr", 32'(sync_err), 0);
        r_frame = 1'b1;
        r_gray  = 10'h2ab;
        cyc();
        chk("resync.serr", 32'(sync_err), 1);
        chk_wr("resync.prev", 32'h163, 32'(rval(99)));
        r_frame = 1'b0;
        r_gray  = 10'h015;
        cyc();
        idle_in();
        chk_wr("resync.px", 32'h100, 32'h2ab);
        cyc();
        chk_wr("resync.nx", 32'h101, 32'h015);
        chk("resync.fd", 32'(frame_done), 0);

        // Asynchronous reset mid-frame
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            l_valid = 1'b1;
            l_frame = (i == 0);
            l_gray  = 10'(200 + i);
            cyc();
        end
        idle_in();
        mem_ready = 1'b1;
        cyc();
        chk_wr("pre.rst", 0, 200);
        chk("pre.rst.ovf", 32'(overflow), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("async");
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            l_valid = 1'b1;
            l_gray  = 10'(300 + i);
            cyc();
            chk("post.we", 32'(mem_we), 0);
        end
        l_frame = 1'b1;
        l_gray  = 10'h3ff;
        cyc();
        idle_in();
        chk("post.mk.we", 32'(mem_we), 0);
        cyc();
        chk_wr("post.wr", 0, 32'h3ff);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nbad);
        $finish;
    end

endmodule
